test_27: RTL and testbench



---
 rtl/test_27.sv | 76 +++++++
 tb/tb_test_27.sv | 136 +++++++++++++
 2 files changed

// File: rtl/test_27.sv
// rtl/test_27.sv - free-running modulo-N up-counter with optional Gray-coded output
//
// Purpose:
//   Counts 0..MAX_CNT and wraps to 0. It is a standalone count source for
//   tick and sequence generation. The output is registered and has no handshake.
//   Optional build macro TEST27_GRAY_EN: when it is defined, o_cnt carries the
//   Gray code of the binary count. That mode requires MAX_CNT == 2**WIDTH-1 so
//   that the wrap also changes only one bit.
//
// Parameters:
//   WIDTH    counter/output width in bits (1..16)
//   MAX_CNT  terminal count, MAX_CNT <= 2**WIDTH-1
//
// Ports:
//   clk    in   1      clock, rising edge
//   rst_n  in   1      asynchronous reset, active HIGH despite the name
//   o_cnt  out  WIDTH  current count (binary, or Gray with TEST27_GRAY_EN)

module test_27 #(
  parameter int WIDTH   = 4,
  parameter int MAX_CNT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] o_cnt
);

  localparam logic [WIDTH-1:0] MAX_V = MAX_CNT[WIDTH-1:0];

  if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
    $error("test_27: WIDTH must be in 1..16");
  end
  if (MAX_CNT < 0 || MAX_CNT > (2**WIDTH) - 1) begin : g_bad_max
    $error("test_27: MAX_CNT must be in 0..2**WIDTH-1");
  end

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_next;

  // The >= comparison also covers an out-of-range state (cnt > MAX_CNT, for
  // example after an upset). That state reloads 0 on the next edge rather
  // than running on to the natural rollover.
  always_comb begin
    cnt_next = cnt + 1'b1;
    if (cnt >= MAX_V) begin
      cnt_next = '0;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next;
    end
  end

`ifdef TEST27_GRAY_EN
  if (MAX_CNT != (2**WIDTH) - 1) begin : g_bad_gray
    $error("test_27: Gray output needs MAX_CNT == 2**WIDTH-1");
  end

  // The Gray value is encoded from cnt_next. The output register therefore
  // updates on the same edge as the binary count, with no extra stage.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      o_cnt <= '0;
    end else begin
      o_cnt <= cnt_next ^ (cnt_next >> 1);
    end
  end
`else
  assign o_cnt = cnt;
`endif

endmodule

// File: tb/tb_test_27.sv
// tb/tb_test_27.sv - directed self-checking bench for test_27

module tb_test_27;

  logic       clk;
  logic       rst_n;
  logic [3:0] cnt16;
  logic [3:0] cnt10;

  int checks;
  int passed;
  int fails;

  test_27 #(.WIDTH(4), .MAX_CNT(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .o_cnt (cnt16)
  );

`ifndef TEST27_GRAY_EN
  test_27 #(.WIDTH(4), .MAX_CNT(9)) dut9 (
    .clk   (clk),
    .rst_n (rst_n),
    .o_cnt (cnt10)
  );
`else
  assign cnt10 = '0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] enc(input logic [3:0] b);
`ifdef TEST27_GRAY_EN
    return b ^ (b >> 1);
`else
    return b;
`endif
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check10(input string tag, input logic [3:0] exp);
`ifndef TEST27_GRAY_EN
    check(tag, cnt10, exp);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] prev;

  initial begin
    checks = 0;
    passed = 0;
    fails  = 0;
    rst_n  = 1'b1;
    #1;
    check("reset_immediate", cnt16, 4'd0);
    check10("reset_immediate_m9", 4'd0);

    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_hold", cnt16, 4'd0);
      check10("reset_hold_m9", 4'd0);
    end

    #2;
    rst_n = 1'b0;
    #1;
    check("release_no_change", cnt16, 4'd0);

    // 17 edges from 0 give 1..15, then 0, then 1.
    prev = cnt16;
    for (int k = 1; k <= 17; k++) begin
      tick();
      check("count_wrap", cnt16, enc(4'((k) % 16)));
      check10("count_mod10", 4'((k) % 10));
`ifdef TEST27_GRAY_EN
      check("gray_one_bit", 4'($countones(cnt16 ^ prev)), 4'd1);
`endif
      prev = cnt16;
    end

    // The count is now 1. Run on to 9.
    for (int k = 2; k <= 9; k++) begin
      tick();
    end
    check("reached_nine", cnt16, enc(4'd9));

    #2;
    rst_n = 1'b1;
    #1;
    check("async_mid_count", cnt16, 4'd0);
    check10("async_mid_count_m9", 4'd0);
    tick();
    check("held_in_reset", cnt16, 4'd0);
    #2;
    rst_n = 1'b0;
    tick();
    check("restart_one", cnt16, enc(4'd1));
    check10("restart_one_m9", 4'd1);
    tick();
    check("restart_two", cnt16, enc(4'd2));

    // Assert reset right at a rising edge. Reset must win.
    @(posedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_at_edge", cnt16, 4'd0);
    #2;
    rst_n = 1'b0;
    tick();
    check("after_edge_reset", cnt16, enc(4'd1));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
